// File: rtl/display_scanner.sv
// display_scanner
//
// Time-multiplexed driver for a row of common-anode seven-segment digits.
// One digit slot is selected at a time. Its nibble is presented on `digit`
// for an external seven-segment decoder, and its active-low anode is pulled
// low. Each slot starts with a dead-time (blank) interval so the decoder can
// settle before the digit lights. This prevents ghosting. Newly loaded
// values are held in `pending` and copied into `shown` only at a frame
// boundary, so a frame never mixes two values.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high; clears all state and outputs
//   value      : 4*NUM_DIGITS hex value, nibble i feeds slot i (slot 0 = LSD)
//   load       : one-cycle strobe, captures `value` into the pending register
//   enable     : level, scanning runs while high
//   lz_blank   : level, suppress leading-zero digits when high
//   digit      : nibble of the current slot (registered)
//   anodes     : active-low digit enables, at most one low (registered)
//   frame_done : one-cycle pulse after the last slot's drive phase (registered)
module display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    lz_blank,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int VW    = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [VW-1:0]     pending, pending_nx;
    logic [VW-1:0]     shown, shown_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [3:0]        digit_nx;
    logic [NUM_DIGITS-1:0] anodes_nx;
    logic              frame_done_nx;

    // Anode pattern for the drive phase of slot i. Slot i (i >= 1) stays dark
    // when leading-zero blanking is on and nibbles i..NUM_DIGITS-1 are all zero.
    function automatic logic [NUM_DIGITS-1:0] drive_anodes(
        input logic [IDX_W-1:0] i,
        input logic [VW-1:0]    v,
        input logic             lz
    );
        logic upper_zero;
        logic [NUM_DIGITS-1:0] a;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(i) && v[4*k +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        a = '1;
        if (!(lz && i != '0 && upper_zero))
            a[i] = 1'b0;
        return a;
    endfunction

    function automatic logic [3:0] nibble_of(
        input logic [VW-1:0]    v,
        input logic [IDX_W-1:0] i
    );
        return v[4*int'(i) +: 4];
    endfunction

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        cnt_nx        = cnt;
        shown_nx      = shown;
        pending_nx    = load ? value : pending;
        digit_nx      = digit;
        anodes_nx     = anodes;
        frame_done_nx = 1'b0;

        case (state)
            IDLE: begin
                idx_nx    = '0;
                cnt_nx    = '0;
                anodes_nx = '1;
                if (enable)
                    state_nx = BLANK;
            end
            BLANK: begin
                if (!enable) begin
                    state_nx  = IDLE;
                    idx_nx    = '0;
                    cnt_nx    = '0;
                    anodes_nx = '1;
                end else if (cnt == BLANK_END) begin
                    state_nx  = DRIVE;
                    cnt_nx    = cnt + CNT_W'(1);
                    anodes_nx = drive_anodes(idx, shown, lz_blank);
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DRIVE: begin
                if (!enable) begin
                    state_nx  = IDLE;
                    idx_nx    = '0;
                    cnt_nx    = '0;
                    anodes_nx = '1;
                end else if (cnt == SLOT_END) begin
                    state_nx      = BLANK;
                    cnt_nx        = '0;
                    anodes_nx     = '1;
                    frame_done_nx = (idx == LAST_IDX);
                    idx_nx        = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx  = IDLE;
                idx_nx    = '0;
                cnt_nx    = '0;
                anodes_nx = '1;
            end
        endcase

        // Entering BLANK: a frame boundary latches the new value (a load in
        // this same cycle bypasses pending), and the decoder input is updated
        // here so it is stable well before the anode turns on.
        if (state_nx == BLANK && state != BLANK) begin
            if (idx_nx == '0)
                shown_nx = load ? value : pending;
            digit_nx = nibble_of(shown_nx, idx_nx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            shown      <= '0;
            idx        <= '0;
            cnt        <= '0;
            digit      <= 4'h0;
            anodes     <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            pending    <= pending_nx;
            shown      <= shown_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            digit      <= digit_nx;
            anodes     <= anodes_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int FP = N * R;

    logic          clk;
    logic          reset;
    logic [15:0]   value;
    logic          load;
    logic          enable;
    logic          lz_blank;
    logic [3:0]    digit;
    logic [3:0]    anodes;
    logic          frame_done;

    int vectors;
    int miscompares;
    logic [15:0] model_pending;

    display_scanner #(
        .NUM_DIGITS(N),
        .REFRESH_DIV(R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .reset(reset),
        .value(value),
        .load(load),
        .enable(enable),
        .lz_blank(lz_blank),
        .digit(digit),
        .anodes(anodes),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what the display should look like t cycles after the first
    // BLANK cycle of a scan, for the value latched in that frame.
    function automatic logic [3:0] exp_digit(input logic [15:0] sv, input int t);
        int slot;
        slot = (t % FP) / R;
        return 4'((sv >> (4 * slot)) & 16'hF);
    endfunction

    function automatic logic [3:0] exp_anodes(input logic [15:0] sv, input logic lz, input int t);
        int slot;
        int phase;
        logic [3:0] a;
        slot  = (t % FP) / R;
        phase = t % R;
        if (phase < B) return 4'hF;
        if (lz && slot > 0 && (sv >> (4 * slot)) == 16'h0) return 4'hF;
        a = 4'hF;
        a[slot] = 1'b0;
        return a;
    endfunction

    // Checks ncycles consecutive cycles starting at the first BLANK cycle of
    // a scan. Optionally pulses load once, at cycle load_at.
    task automatic check_run(input int ncycles, input int load_at, input logic [15:0] load_val,
                             input string name);
        logic [15:0] frame_val;
        logic [15:0] next_val;
        logic [3:0]  ed;
        logic [3:0]  ea;
        logic        ef;
        frame_val = model_pending;
        next_val  = model_pending;
        for (int t = 0; t < ncycles; t++) begin
            if (t > 0 && t % FP == 0) frame_val = next_val;
            ed = exp_digit(frame_val, t);
            ea = exp_anodes(frame_val, lz_blank, t);
            ef = (t > 0 && t % FP == 0);
            vectors++;
            if (digit !== ed || anodes !== ea || frame_done !== ef) begin
                miscompares++;
                $display("FAIL %s t=%0d: got digit=%h anodes=%b fd=%b, expected digit=%h anodes=%b fd=%b",
                         name, t, digit, anodes, frame_done, ed, ea, ef);
            end
            if (t == load_at) begin
                load  = 1'b1;
                value = load_val;
                model_pending = load_val;
            end else begin
                load = 1'b0;
            end
            if ((t + 1) % FP == 0) next_val = model_pending;
            tick();
        end
        load = 1'b0;
    endtask

    task automatic start_scan(input logic [15:0] v, input bit coincident);
        value = v;
        load  = 1'b1;
        model_pending = v;
        if (coincident) begin
            enable = 1'b1;
            tick();
            load = 1'b0;
        end else begin
            tick();
            load   = 1'b0;
            enable = 1'b1;
            tick();
        end
    endtask

    task automatic stop_scan(input string name);
        enable = 1'b0;
        tick();
        vectors++;
        if (anodes !== 4'hF || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got anodes=%b fd=%b, expected anodes=1111 fd=0", name, anodes, frame_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; enable = 1'b0; lz_blank = 1'b0; value = 16'h0;
        tick();
        tick();
        reset = 1'b0;
        model_pending = 16'h0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (digit !== 4'h0 || anodes !== 4'hF || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle c=%0d: got digit=%h anodes=%b fd=%b, expected 0 1111 0",
                         i, digit, anodes, frame_done);
            end
            tick();
        end
    endtask

    task automatic test_basic_scan();
        lz_blank = 1'b0;
        start_scan(16'h1234, 1'b0);
        check_run(FP + 2, -1, 16'h0, "scan_1234");
        stop_scan("scan_1234_stop");
    endtask

    task automatic test_leading_zero();
        lz_blank = 1'b1;
        start_scan(16'h0050, 1'b0);
        check_run(FP, -1, 16'h0, "lz_0050");
        stop_scan("lz_0050_stop");
        start_scan(16'h0000, 1'b1);
        check_run(FP, -1, 16'h0, "lz_0000");
        stop_scan("lz_0000_stop");
        lz_blank = 1'b0;
    endtask

    task automatic test_midframe_load();
        start_scan(16'h1234, 1'b0);
        check_run(2 * FP, R + 4, 16'hABCD, "midframe_load");
        stop_scan("midframe_stop");
        start_scan(16'h1234, 1'b0);
        check_run(2 * FP, FP - 1, 16'hABCD, "boundary_load");
        stop_scan("boundary_stop");
    endtask

    task automatic test_enable_drop();
        start_scan(16'h1234, 1'b0);
        check_run(2 * R + 4, -1, 16'h0, "pre_drop");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (anodes !== 4'hF || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL enable_drop c=%0d: got anodes=%b fd=%b, expected 1111 0", i, anodes, frame_done);
            end
        end
        enable = 1'b1;
        tick();
        check_run(FP + 1, -1, 16'h0, "reenable");
        stop_scan("reenable_stop");
    endtask

    task automatic test_reset_midframe();
        start_scan(16'h1234, 1'b0);
        check_run(R + 4, -1, 16'h0, "pre_reset");
        reset  = 1'b1;
        load   = 1'b1;
        value  = 16'h9876;
        enable = 1'b1;
        tick();
        vectors++;
        if (digit !== 4'h0 || anodes !== 4'hF || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got digit=%h anodes=%b fd=%b, expected 0 1111 0", digit, anodes, frame_done);
        end
        reset = 1'b0;
        load  = 1'b0;
        model_pending = 16'h0;
        tick();
        check_run(FP, -1, 16'h0, "post_reset_frame");
        stop_scan("post_reset_stop");
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [15:0] lv;
        int la;
        for (int i = 0; i < 8; i++) begin
            v  = 16'($urandom);
            v  = v >> (4 * $urandom_range(0, 3));
            lv = 16'($urandom) >> (4 * $urandom_range(0, 3));
            la = int'($urandom_range(0, 2 * FP - 2));
            lz_blank = 1'($urandom);
            start_scan(v, 1'($urandom));
            check_run(3 * FP, la, lv, "random");
            stop_scan("random_stop");
        end
        lz_blank = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; load = 1'b0; enable = 1'b0; lz_blank = 1'b0; value = 16'h0;
        model_pending = 16'h0;
        test_reset();
        test_basic_scan();
        test_leading_zero();
        test_midframe_load();
        test_enable_drop();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
